// File: rtl/ibex_pkg.sv
// Shared types and helpers for the fetch alignment FIFO.
// Each FIFO entry holds one 32-bit bus response word and its error flag.
package ibex_pkg;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } fetch_fifo_entry_t;

   localparam int unsigned FetchFifoDepthDefault = 3;

   // A RISC-V halfword starts a compressed instruction unless its two low bits are both set.
   function automatic logic is_compressed(input logic [15:0] halfword);
      return halfword[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/ibex_fetch_aligner.sv
// Combinational head decoder: builds the aligned instruction from the two oldest
// FIFO words and decides how far the PC advances and whether the head word retires.
module ibex_fetch_aligner
   import ibex_pkg::*;
(
   input  logic              unaligned_i,
   input  fetch_fifo_entry_t e0_i,
   input  logic              v0_i,
   input  fetch_fifo_entry_t e1_i,
   input  logic              v1_i,
   output logic              out_valid_o,
   output logic [31:0]       out_rdata_o,
   output logic              out_err_o,
   output logic              out_err_plus2_o,
   output logic              pop_entry_o,
   output logic              incr4_o
);

   logic [15:0] loHalf;
   logic        errRaw;
   logic        plusTwoRaw;

   always_comb begin
      loHalf      = e0_i.rdata[31:16];
      out_valid_o = v0_i;
      out_rdata_o = e0_i.rdata;
      errRaw      = e0_i.err;
      plusTwoRaw  = 1'b0;
      pop_entry_o = 1'b1;
      incr4_o     = 1'b1;
      if (!unaligned_i) begin
         // A clean aligned compressed instruction leaves the upper half of the word for next time.
         if (!e0_i.err && is_compressed(e0_i.rdata[15:0])) begin
            pop_entry_o = 1'b0;
            incr4_o     = 1'b0;
         end
      end else begin
         out_rdata_o = {e1_i.rdata[15:0], loHalf};
         if (e0_i.err) begin
            errRaw = 1'b1;
         end else if (is_compressed(loHalf)) begin
            errRaw  = 1'b0;
            incr4_o = 1'b0;
         end else begin
            out_valid_o = v0_i & v1_i;
            errRaw      = e1_i.err;
            plusTwoRaw  = e1_i.err;
         end
      end
   end

   // Error flags are only meaningful alongside a valid head, so stale storage never leaks out.
   assign out_err_o       = out_valid_o & errRaw;
   assign out_err_plus2_o = out_valid_o & plusTwoRaw;

endmodule

// File: rtl/ibex_fetch_align_fifo.sv
// Fetch FIFO between the instruction bus and IF/ID: buffers response words,
// realigns straddling instructions and tracks the PC of the head instruction.
module ibex_fetch_align_fifo
   import ibex_pkg::*;
#(
   parameter int unsigned Depth    = FetchFifoDepthDefault,
   parameter int unsigned NumReqs  = 2,
   parameter bit          ResetAll = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic [31:0] clear_addr_i,
   output logic        busy_o,
   input  logic        in_valid_i,
   input  logic [31:0] in_rdata_i,
   input  logic        in_err_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_rdata_o,
   output logic [31:0] out_addr_o,
   output logic        out_err_o,
   output logic        out_err_plus2_o
);

   localparam int unsigned CntW = $clog2(Depth + 1);

   fetch_fifo_entry_t entries_q [Depth];
   fetch_fifo_entry_t entries_d [Depth];
   logic [CntW-1:0]   count_q, count_d, countAfterPop;
   logic [31:0]       addr_q, addr_d;
   logic [Depth-1:0]  validVec;
   logic              popEntry, incrBy4, handshake, popWord, pushWord;
   logic              unusedAddrBit;

   assign unusedAddrBit = clear_addr_i[0];

   always_comb begin
      validVec = '0;
      for (int i = 0; i < int'(Depth); i++) begin
         validVec[i] = i < int'(count_q);
      end
   end

   ibex_fetch_aligner u_aligner (
      .unaligned_i     (addr_q[1]),
      .e0_i            (entries_q[0]),
      .v0_i            (validVec[0]),
      .e1_i            (entries_q[1]),
      .v1_i            (validVec[1]),
      .out_valid_o     (out_valid_o),
      .out_rdata_o     (out_rdata_o),
      .out_err_o       (out_err_o),
      .out_err_plus2_o (out_err_plus2_o),
      .pop_entry_o     (popEntry),
      .incr4_o         (incrBy4)
   );

   assign out_addr_o    = addr_q;
   assign handshake     = out_valid_o & out_ready_i & ~clear_i;
   assign popWord       = handshake & popEntry;
   assign countAfterPop = count_q - CntW'(popWord);
   assign pushWord      = in_valid_i & ~clear_i & (countAfterPop != CntW'(Depth));
   assign busy_o        = int'(count_q) > (int'(Depth) - int'(NumReqs));

   // Shift on pop, then the incoming word lands in the lowest slot that is free after the shift.
   always_comb begin
      entries_d = entries_q;
      if (popWord) begin
         for (int i = 0; i < int'(Depth) - 1; i++) begin
            entries_d[i] = entries_q[i+1];
         end
      end
      if (pushWord) begin
         for (int i = 0; i < int'(Depth); i++) begin
            if (CntW'(i) == countAfterPop) begin
               entries_d[i] = {in_rdata_i, in_err_i};
            end
         end
      end
   end

   always_comb begin
      count_d = countAfterPop + CntW'(pushWord);
      addr_d  = addr_q;
      if (clear_i) begin
         count_d = '0;
         addr_d  = {clear_addr_i[31:1], 1'b0};
      end else if (handshake) begin
         addr_d = addr_q + (incrBy4 ? 32'd4 : 32'd2);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         addr_q  <= '0;
      end else begin
         count_q <= count_d;
         addr_q  <= addr_d;
      end
   end

   if (ResetAll) begin : g_storage_reset
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
               entries_q[i] <= '0;
            end
         end else begin
            entries_q <= entries_d;
         end
      end
   end else begin : g_storage_noreset
      always_ff @(posedge clk_i) begin
         entries_q <= entries_d;
      end
   end

   // The requester must never deliver a response it has no room for.
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(in_valid_i && !clear_i && (countAfterPop == CntW'(Depth))));

endmodule

// File: tb/tb_ibex_fetch_align_fifo.sv
// Randomized bench for the fetch alignment FIFO, checked against a halfword-stream
// reference model plus a few directed scenarios with hand-computed expectations.
module tb_ibex_fetch_align_fifo;

   localparam int unsigned Depth   = 3;
   localparam int unsigned NumReqs = 2;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        clear_i = 1'b0;
   logic [31:0] clear_addr_i = '0;
   logic        busy_o;
   logic        in_valid_i = 1'b0;
   logic [31:0] in_rdata_i = '0;
   logic        in_err_i = 1'b0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [31:0] out_rdata_o;
   logic [31:0] out_addr_o;
   logic        out_err_o;
   logic        out_err_plus2_o;

   int vecCount  = 0;
   int missCount = 0;

   typedef struct {
      logic [15:0] h;
      logic        e;
   } half_t;

   // The model sees the FIFO as a stream of halfwords starting at the head PC.
   half_t       hq[$];
   logic [31:0] mAddr;

   always #5 clk_i = ~clk_i;

   ibex_fetch_align_fifo #(.Depth(Depth), .NumReqs(NumReqs), .ResetAll(1'b0)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .clear_i         (clear_i),
      .clear_addr_i    (clear_addr_i),
      .busy_o          (busy_o),
      .in_valid_i      (in_valid_i),
      .in_rdata_i      (in_rdata_i),
      .in_err_i        (in_err_i),
      .out_valid_o     (out_valid_o),
      .out_ready_i     (out_ready_i),
      .out_rdata_o     (out_rdata_o),
      .out_addr_o      (out_addr_o),
      .out_err_o       (out_err_o),
      .out_err_plus2_o (out_err_plus2_o)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecCount++;
      if (obs !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int modelWords();
      return (hq.size() + int'(mAddr[1])) / 2;
   endfunction

   task automatic modelHead(output logic v, output logic err, output logic p2,
                            output logic [31:0] d, output logic [31:0] mask, output logic inc4);
      v = 0; err = 0; p2 = 0; d = '0; mask = '0; inc4 = 1;
      if (hq.size() > 0) begin
         if (hq[0].e) begin
            v = 1; err = 1;
         end else if (hq[0].h[1:0] != 2'b11) begin
            v = 1; inc4 = 0; d = {16'h0, hq[0].h}; mask = 32'h0000_ffff;
         end else if (hq.size() > 1) begin
            v = 1; err = hq[1].e; p2 = hq[1].e; d = {hq[1].h, hq[0].h}; mask = '1;
         end
      end
   endtask

   task automatic applyStimulus(input logic clr, input logic [31:0] caddr, input logic iv,
                                input logic [31:0] data, input logic ierr, input logic rdy);
      logic v, err, p2, inc4, ivEff;
      logic [31:0] d, mask;
      @(negedge clk_i);
      modelHead(v, err, p2, d, mask, inc4);
      checkOutput("valid", {31'b0, out_valid_o}, {31'b0, v});
      checkOutput("busy", {31'b0, busy_o}, {31'b0, modelWords() > int'(Depth) - int'(NumReqs)});
      checkOutput("addr", out_addr_o, mAddr);
      if (v) begin
         checkOutput("err", {31'b0, out_err_o}, {31'b0, err});
         checkOutput("plus2", {31'b0, out_err_plus2_o}, {31'b0, p2});
         checkOutput("rdata", out_rdata_o & mask, d);
      end
      if (v && rdy && !clr) begin
         for (int k = 0; k < (inc4 ? 2 : 1); k++) begin
            if (hq.size() > 0) void'(hq.pop_front());
         end
         mAddr = mAddr + (inc4 ? 32'd4 : 32'd2);
      end
      ivEff = iv && (clr || modelWords() < int'(Depth));
      if (clr) begin
         hq.delete();
         mAddr = {caddr[31:1], 1'b0};
      end else if (ivEff) begin
         if (!(mAddr[1] && hq.size() == 0)) hq.push_back('{h: data[15:0], e: ierr});
         hq.push_back('{h: data[31:16], e: ierr});
      end
      clear_i      = clr;
      clear_addr_i = caddr;
      in_valid_i   = ivEff;
      in_rdata_i   = data;
      in_err_i     = ierr;
      out_ready_i  = rdy;
      @(posedge clk_i);
      #1;
      clear_i     = 1'b0;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
   endtask

   task automatic doReset();
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      hq.delete();
      mAddr = '0;
      checkOutput("rst_valid", {31'b0, out_valid_o}, 32'd0);
      checkOutput("rst_err", {31'b0, out_err_o}, 32'd0);
      checkOutput("rst_plus2", {31'b0, out_err_plus2_o}, 32'd0);
      checkOutput("rst_busy", {31'b0, busy_o}, 32'd0);
      checkOutput("rst_addr", out_addr_o, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   function automatic logic [15:0] randHalf();
      logic [15:0] h;
      h = 16'($urandom);
      if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
      return h;
   endfunction

   initial begin
      doReset();

      // Compressed pair in one aligned word.
      applyStimulus(1, 32'h0000_0080, 0, '0, 0, 0);
      applyStimulus(0, '0, 1, 32'h0041_4501, 0, 0);
      checkOutput("c_valid", {31'b0, out_valid_o}, 32'd1);
      checkOutput("c_addr", out_addr_o, 32'h80);
      checkOutput("c_rdata", {16'h0, out_rdata_o[15:0]}, 32'h4501);
      applyStimulus(0, '0, 0, '0, 0, 1);
      checkOutput("c2_addr", out_addr_o, 32'h82);
      checkOutput("c2_rdata", {16'h0, out_rdata_o[15:0]}, 32'h0041);
      applyStimulus(0, '0, 0, '0, 0, 1);
      checkOutput("c3_addr", out_addr_o, 32'h84);
      checkOutput("c3_valid", {31'b0, out_valid_o}, 32'd0);

      // Unaligned 32-bit instruction straddling two words.
      applyStimulus(1, 32'h0000_0102, 0, '0, 0, 0);
      applyStimulus(0, '0, 1, 32'hFFFF_0013, 0, 0);
      checkOutput("u_valid_half", {31'b0, out_valid_o}, 32'd0);
      applyStimulus(0, '0, 1, 32'h1234_0093, 0, 0);
      checkOutput("u_valid", {31'b0, out_valid_o}, 32'd1);
      checkOutput("u_rdata", out_rdata_o, 32'h0093_FFFF);
      checkOutput("u_addr", out_addr_o, 32'h102);
      applyStimulus(0, '0, 0, '0, 0, 1);
      checkOutput("u_addr_pop", out_addr_o, 32'h106);
      checkOutput("u_busy_pop", {31'b0, busy_o}, 32'd0);

      // Error in the upper half of an unaligned instruction.
      applyStimulus(1, 32'h0000_0102, 0, '0, 0, 0);
      applyStimulus(0, '0, 1, 32'hFFFF_0013, 0, 0);
      applyStimulus(0, '0, 1, 32'h0000_0000, 1, 0);
      checkOutput("e2_err", {31'b0, out_err_o}, 32'd1);
      checkOutput("e2_plus2", {31'b0, out_err_plus2_o}, 32'd1);
      checkOutput("e2_addr", out_addr_o, 32'h102);

      // Headroom: two words held leaves no room for two more responses.
      applyStimulus(1, 32'h0, 0, '0, 0, 0);
      applyStimulus(0, '0, 1, 32'h0000_0013, 0, 0);
      applyStimulus(0, '0, 1, 32'h0000_0013, 0, 0);
      checkOutput("b_busy", {31'b0, busy_o}, 32'd1);
      applyStimulus(0, '0, 0, '0, 0, 1);
      checkOutput("b_busy_pop", {31'b0, busy_o}, 32'd0);

      // Clear wins over simultaneous push and pop.
      applyStimulus(1, 32'h0000_0200, 1, 32'hDEAD_BEEF, 0, 1);
      checkOutput("clr_valid", {31'b0, out_valid_o}, 32'd0);
      checkOutput("clr_addr", out_addr_o, 32'h200);
      checkOutput("clr_busy", {31'b0, busy_o}, 32'd0);

      // PC wraps around the top of the address space.
      applyStimulus(1, 32'hFFFF_FFFC, 0, '0, 0, 0);
      applyStimulus(0, '0, 1, 32'h0000_0013, 0, 0);
      applyStimulus(0, '0, 0, '0, 0, 1);
      checkOutput("wrap_addr", out_addr_o, 32'h0);
      checkOutput("wrap_valid", {31'b0, out_valid_o}, 32'd0);

      for (int n = 0; n < 3000; n++) begin
         if (n % 1000 == 999) doReset();
         applyStimulus($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 2) != 0,
                       {randHalf(), randHalf()}, $urandom_range(0, 15) == 0,
                       $urandom_range(0, 1) == 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
